angle_display_ctrl: RTL and testbench

ANGLE_DISPLAY_CTRL -- requirements
Module: angle_display_ctrl

---
 rtl/angle_display_ctrl.sv | 178 +++++++++++++++++
 tb/tb_angle_display_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/angle_display_ctrl.sv
// Angle display controller: scales a 12-bit encoder count to degrees,
// converts the result to three BCD digits with a serial double-dabble,
// and multiplexes the registered result onto a 3-digit 7-segment display.
//
// Handshake: req is level-sampled only while the FSM is in IDLE, and angle
// is captured on that same edge. busy is high for the whole conversion.
// done pulses for exactly one cycle, in the first cycle that bcd holds the
// new result. There is no back-pressure; req seen outside IDLE is ignored.
module angle_display_ctrl #(
   parameter int SCAN_DIV = 50000,
   parameter int DEG_MAX  = 359
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] angle,
   input  logic        req,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd,
   output logic [6:0]  seg,
   output logic [2:0]  dig_en,
   output logic [1:0]  dbg_state
);

   // IDLE is encoded as 0 so that a zero on dbg_state means "idle".
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCALE   = 2'd1,
      CONVERT = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [11:0] ang_q;
   logic [8:0]  deg_sh;
   logic [11:0] work;
   logic [3:0]  step;

   logic [21:0] prod;
   logic [21:0] deg_full;
   logic [8:0]  deg_sat;
   logic [11:0] work_adj;
   logic [11:0] work_nxt;

   logic [19:0] pre;
   logic [1:0]  idx;
   logic [1:0]  idx_nxt;
   logic        wrap;
   logic [3:0]  digit;
   logic        blank;

   // Standard active-low 7-segment pattern, {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; the 9th CONVERT step is the one with step == 8.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = SCALE;
         SCALE:   state_nxt = CONVERT;
         CONVERT: if (step == 4'd8) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy      = (state != IDLE);
      done      = (state == DONE);
      dbg_state = state;
   end

   // Degree scaling: floor(358*angle/1000), saturated to DEG_MAX.
   always_comb begin
      prod     = 22'(ang_q) * 22'd358;
      deg_full = prod / 22'd1000;
      deg_sat  = (deg_full > 22'(DEG_MAX)) ? 9'(DEG_MAX) : deg_full[8:0];
   end

   // One double-dabble step: add 3 to digits >= 5, then shift in next deg bit.
   always_comb begin
      work_adj = work;
      for (int i = 0; i < 3; i++) begin
         if (work[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
      end
      work_nxt = {work_adj[10:0], deg_sh[8]};
   end

   // Conversion datapath; bcd only changes when a full conversion completes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ang_q  <= '0;
         deg_sh <= '0;
         work   <= '0;
         step   <= '0;
         bcd    <= '0;
      end else begin
         case (state)
            IDLE: if (req) ang_q <= angle;
            SCALE: begin
               deg_sh <= deg_sat;
               work   <= '0;
               step   <= '0;
            end
            CONVERT: begin
               work   <= work_nxt;
               deg_sh <= {deg_sh[7:0], 1'b0};
               step   <= step + 4'd1;
               if (step == 4'd8) bcd <= work_nxt;
            end
            default: ;
         endcase
      end
   end

   // Scan index sequencing and digit selection with leading-zero blanking.
   always_comb begin
      wrap    = (pre == 20'(SCAN_DIV - 1));
      idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      case (idx_nxt)
         2'd1: begin
            digit = bcd[7:4];
            blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
         end
         2'd2: begin
            digit = bcd[11:8];
            blank = (bcd[11:8] == 4'd0);
         end
         default: begin
            digit = bcd[3:0];
            blank = 1'b0;
         end
      endcase
   end

   // Free-running prescaler; seg/dig_en update only when the index advances.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre    <= '0;
         idx    <= 2'd0;
         dig_en <= 3'b110;
         seg    <= 7'b1000000;
      end else if (wrap) begin
         pre <= '0;
         idx <= idx_nxt;
         seg <= blank ? 7'b1111111 : seg7(digit);
         case (idx_nxt)
            2'd1:    dig_en <= 3'b101;
            2'd2:    dig_en <= 3'b011;
            default: dig_en <= 3'b110;
         endcase
      end else begin
         pre <= pre + 20'd1;
      end
   end

endmodule

// File: tb/tb_angle_display_ctrl.sv
// Bench for angle_display_ctrl: vector table, random angles against a
// plain-arithmetic degree/BCD model, and hand-written multi-cycle sequences.
module tb_angle_display_ctrl;

   localparam int SCAN_DIV = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] angle;
   logic        req;
   logic        busy;
   logic        done;
   logic [11:0] bcd;
   logic [6:0]  seg;
   logic [2:0]  dig_en;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [11:0] a;
      logic [11:0] exp_bcd;
   } vec_t;

   vec_t        vecs[10];
   logic [6:0]  seg_tab[10];
   logic [11:0] exp_q[$];

   angle_display_ctrl #(.SCAN_DIV(SCAN_DIV), .DEG_MAX(359)) dut (
      .clk(clk), .rst_n(rst_n), .angle(angle), .req(req),
      .busy(busy), .done(done), .bcd(bcd), .seg(seg),
      .dig_en(dig_en), .dbg_state(dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // reference: degrees from plain arithmetic, then decimal digits
   function automatic logic [11:0] model(input int a);
      int d;
      d = (358 * a) / 1000;
      if (d > 359) d = 359;
      return {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one request, checks busy, latency (accept edge counted as edge 1), result, pulse width
   task automatic do_conv(input logic [11:0] a, input logic [11:0] exp);
      int n;
      angle = a;
      req   = 1'b1;
      tick();
      req = 1'b0;
      n   = 1;
      chk("busy_rise", busy, 1);
      while (!done && n < 20) begin
         tick();
         n++;
      end
      chk("done_seen", done, 1);
      chk("latency", n, 11);
      chk("bcd", bcd, exp);
      tick();
      chk("done_width", done, 0);
      chk("busy_fall", busy, 0);
   endtask

   // observe three digit slots and compare against the expected bcd
   task automatic check_scan(input logic [11:0] exp);
      int pidx;
      int idx;
      int c;
      logic [2:0] d0;
      logic [6:0] es;
      pidx = -1;
      for (int k = 0; k < 3; k++) begin
         d0 = dig_en;
         c  = 0;
         while (dig_en == d0 && c < 4 * SCAN_DIV) begin
            tick();
            c++;
         end
         chk("scan_advance", (dig_en != d0), 1);
         case (dig_en)
            3'b110:  idx = 0;
            3'b101:  idx = 1;
            3'b011:  idx = 2;
            default: idx = -1;
         endcase
         chk("dig_onehot", (idx >= 0), 1);
         if (pidx >= 0) chk("scan_order", idx, (pidx + 1) % 3);
         pidx = idx;
         case (idx)
            0:       es = seg_tab[exp[3:0]];
            1:       es = (exp[11:4] == 8'h00) ? 7'b1111111 : seg_tab[exp[7:4]];
            2:       es = (exp[11:8] == 4'h0) ? 7'b1111111 : seg_tab[exp[11:8]];
            default: es = 7'b1111111;
         endcase
         chk("seg", seg, es);
      end
   endtask

   initial begin
      int n, t1, t2, seen;
      logic [11:0] a;

      seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
      seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
      seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
      seg_tab[9] = 7'b0010000;

      vecs[0] = '{12'd1000, 12'h358};
      vecs[1] = '{12'd4095, 12'h359};
      vecs[2] = '{12'd1005, 12'h359};
      vecs[3] = '{12'd0,    12'h000};
      vecs[4] = '{12'd3,    12'h001};
      vecs[5] = '{12'd500,  12'h179};
      vecs[6] = '{12'd999,  12'h357};
      vecs[7] = '{12'd1003, 12'h359};
      vecs[8] = '{12'd2,    12'h000};
      vecs[9] = '{12'd30,   12'h010};

      // reset held 3 cycles with req asserted (must be ignored)
      rst_n = 1'b0;
      req   = 1'b1;
      angle = 12'd1000;
      for (int i = 0; i < 3; i++) tick();
      req   = 1'b0;
      rst_n = 1'b1;
      chk("rst_bcd", bcd, 12'h000);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dig_en", dig_en, 3'b110);
      chk("rst_seg", seg, 7'b1000000);
      chk("rst_state", dbg_state, 2'd0);
      tick();
      chk("rst_req_ignored", busy, 0);

      // table-driven vectors, each followed by a display scan
      for (int i = 0; i < 10; i++) begin
         do_conv(vecs[i].a, vecs[i].exp_bcd);
         check_scan(vecs[i].exp_bcd);
      end

      // random angles against the model
      for (int i = 0; i < 20; i++) begin
         a = 12'($urandom_range(0, 4095));
         exp_q.push_back(model(int'(a)));
         do_conv(a, exp_q.pop_front());
      end

      // req held high, angle changed during the first CONVERT
      angle = 12'd500;
      req   = 1'b1;
      n = 0; t1 = 0; t2 = 0;
      while (n < 40 && t2 == 0) begin
         tick();
         n++;
         if (n == 4) angle = 12'd0;
         if (done) begin
            if (t1 == 0) begin
               t1 = n;
               chk("b2b_bcd1", bcd, 12'h179);
            end else begin
               t2 = n;
               chk("b2b_bcd2", bcd, 12'h000);
               req = 1'b0;
            end
         end
      end
      req = 1'b0;
      chk("b2b_first", t1, 11);
      chk("b2b_gap", t2 - t1, 12);
      tick();

      // reset on the 5th CONVERT cycle discards the conversion
      do_conv(12'd999, 12'h357);
      angle = 12'd1000;
      req   = 1'b1;
      tick();
      req = 1'b0;
      n   = 1;
      while (n < 6) begin
         tick();
         n++;
      end
      chk("mid_busy", busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_bcd", bcd, 12'h000);
      chk("abort_state", dbg_state, 2'd0);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done) seen = 1;
      end
      chk("abort_no_done", seen, 0);
      do_conv(12'd1000, 12'h358);
      check_scan(12'h358);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
